// File: rtl/inv_addkey_mixcol_seq.sv
// inv_addkey_mixcol_seq: AddRoundKey followed by column-serial InvMixColumns
// for the inverse cipher, with valid/ready on both sides and a final-round bypass.
module inv_addkey_mixcol_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] instate,
   input  logic [127:0] roundkey,
   input  logic         skip_mix,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] outstate,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
   state_t state, state_nx;
   logic [127:0] blk, blk_mx;
   logic [2:0] col_cnt, col_nx;
   logic skip_q, last, accept;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] s);
      logic [7:0] x1 [4], x2 [4], x4 [4], x8 [4], m9 [4], mb [4], md [4], me [4];
      for (int r = 0; r < 4; r++) begin
         x1[r] = s[31-8*r -: 8];
         x2[r] = xt(x1[r]);
         x4[r] = xt(x2[r]);
         x8[r] = xt(x4[r]);
         m9[r] = x8[r] ^ x1[r];
         mb[r] = x8[r] ^ x2[r] ^ x1[r];
         md[r] = x8[r] ^ x4[r] ^ x1[r];
         me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   assign accept    = in_valid && in_ready;
   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign col_nx    = col_cnt + 3'(COLS_PER_CYCLE);
   assign last      = skip_q || col_nx == 3'd4;

   // only the window col_cnt .. col_cnt+COLS_PER_CYCLE-1 is rewritten each cycle
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign blk_mx[127-32*c -: 32] = (col_cnt <= 3'(c) && 3'(c) < col_nx)
                                      ? inv_mix(blk[127-32*c -: 32]) : blk[127-32*c -: 32];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (state == IDLE && in_valid) state_nx = skip_mix ? DONE : PROC;
      else if (state == PROC && last) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         blk      <= '0;
         col_cnt  <= '0;
         skip_q   <= 1'b0;
         outstate <= '0;
      end else if (accept) begin
         blk     <= instate ^ roundkey;
         skip_q  <= skip_mix;
         col_cnt <= '0;
         if (skip_mix) outstate <= instate ^ roundkey;
      end else if (state == PROC) begin
         blk     <= blk_mx;
         col_cnt <= last ? 3'd0 : col_nx;
         if (last) outstate <= blk_mx;
      end
endmodule

// File: tb/tb_inv_addkey_mixcol_seq.sv
// tb_inv_addkey_mixcol_seq: table vectors, back-pressure, mid-run reset and
// streaming across COLS_PER_CYCLE = 1, 2, 4 against a generic GF(2^8) model.
module tb_inv_addkey_mixcol_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] iv, ir, sk, ov, orr, bsy;
   logic [2:0][127:0] ist, rk, os;
   int cyc = 0, checks = 0, failures = 0, mon_idx;
   int acc_cnt [3], hs_cnt [3], acc_edge [3], lat [3], last_hs [3];
   logic [2:0] ov_prev = '0, str_chk = '0;

   typedef struct {int inst; logic [127:0] exp;} sb_t;
   sb_t sbq [$];
   sb_t mon_e;

   typedef struct {logic [127:0] s, k; logic skp; logic [127:0] exp; int lat;} vec_t;
   vec_t tv [4];

   localparam logic [127:0] MIX_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] MIX_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_addkey_mixcol_seq #(.COLS_PER_CYCLE(1 << g)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
         .instate(ist[g]), .roundkey(rk[g]), .skip_mix(sk[g]),
         .out_valid(ov[g]), .out_ready(orr[g]), .outstate(os[g]), .busy(bsy[g]));
   end

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [127:0] k, input logic skp);
      logic [127:0] x, y;
      logic [7:0] m [4];
      logic [7:0] acc;
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      x = s ^ k;
      if (skp) return x;
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gm(m[(j - r + 4) % 4], x[127-32*c-8*j -: 8]);
            y[127-32*c-8*r -: 8] = acc;
         end
      return y;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // scoreboard: push on accept, pop on output handshake
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_n && iv[i] && ir[i]) begin
            mon_e.inst = i;
            mon_e.exp = ref_out(ist[i], rk[i], sk[i]);
            sbq.push_back(mon_e);
            acc_cnt[i]++;
            acc_edge[i] = cyc + 1;
         end
         if (rst_n && ov[i] && !ov_prev[i]) lat[i] = cyc - acc_edge[i];
         if (rst_n && ov[i] && orr[i]) begin
            mon_idx = -1;
            foreach (sbq[q]) if (mon_idx < 0 && sbq[q].inst == i) mon_idx = q;
            if (mon_idx < 0) begin
               checks++;
               failures++;
               $display("FAIL sb%0d unexpected output actual=%h required=none", i, os[i]);
            end else begin
               chk($sformatf("sb%0d_out", i), os[i], sbq[mon_idx].exp);
               sbq.delete(mon_idx);
            end
            if (str_chk[i]) chk($sformatf("gap%0d", i), 128'(cyc - last_hs[i]), 128'(4 / (1 << i) + 2));
            last_hs[i] = cyc;
            hs_cnt[i]++;
         end
         ov_prev[i] = rst_n && ov[i];
      end
   end

   task automatic send(input int i, input logic [127:0] s, input logic [127:0] k, input logic skp, input logic keep);
      int n;
      n = 0;
      @(posedge clk); #1;
      ist[i] = s; rk[i] = k; sk[i] = skp; iv[i] = 1'b1;
      @(negedge clk);
      while (!ir[i] && n < 40) begin @(negedge clk); n++; end
      if (!ir[i]) begin
         checks++;
         failures++;
         $display("FAIL send%0d accept timeout actual=0 required=1", i);
      end
      @(posedge clk); #1;
      if (!keep) begin
         iv[i] = 1'b0; ist[i] = ~s; rk[i] = ~k; sk[i] = ~skp;
      end
   endtask

   task automatic wait_out(input int i, input logic ready_chk);
      int n;
      n = 0;
      @(negedge clk);
      while (!(ov[i] && orr[i]) && n < 60) begin
         if (ready_chk) chk("in_ready_busy_proc", 128'({ir[i], bsy[i]}), 128'(2'b01));
         @(negedge clk);
         n++;
      end
      if (!(ov[i] && orr[i])) begin
         checks++;
         failures++;
         $display("FAIL out%0d timeout actual=0 required=1", i);
      end
      @(posedge clk); #1;
   endtask

   task automatic stream(input int i);
      int base, n;
      base = hs_cnt[i];
      n = 0;
      for (int b = 0; b < 4; b++) send(i, {4{$urandom}}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
      iv[i] = 1'b0;
      while (hs_cnt[i] < base + 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (hs_cnt[i] > base) str_chk[i] = 1'b1;
      end
      str_chk[i] = 1'b0;
      chk($sformatf("stream%0d_count", i), 128'(hs_cnt[i] - base), 128'(4));
   endtask

   initial begin
      logic [127:0] exp_a, s_b, k_b;
      int a0, h0, n;
      iv = '0; sk = '0; orr = '0; ist = '0; rk = '0;
      tv[0] = '{MIX_IN, 128'h0, 1'b0, MIX_OUT, 4};
      tv[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                1'b1, 128'h00102030405060708090a0b0c0d0e0f0, 0};
      tv[2] = '{128'h0, MIX_IN, 1'b0, MIX_OUT, 4};
      tv[3].s = {$urandom, $urandom, $urandom, $urandom};
      tv[3].k = {$urandom, $urandom, $urandom, $urandom};
      tv[3].skp = 1'b0;
      tv[3].exp = ref_out(tv[3].s, tv[3].k, 1'b0);
      tv[3].lat = 4;

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst%0d_in_ready", i), 128'(ir[i]), 128'(1));
         chk($sformatf("rst%0d_out_valid", i), 128'(ov[i]), 128'(0));
         chk($sformatf("rst%0d_busy", i), 128'(bsy[i]), 128'(0));
         chk($sformatf("rst%0d_outstate", i), os[i], 128'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      orr[0] = 1'b1;
      for (int t = 0; t < 4; t++) begin
         send(0, tv[t].s, tv[t].k, tv[t].skp, 1'b0);
         wait_out(0, 1'b1);
         chk($sformatf("tv%0d_out", t), os[0], tv[t].exp);
         chk($sformatf("tv%0d_lat", t), 128'(lat[0]), 128'(tv[t].lat));
      end

      orr[0] = 1'b0;
      exp_a = ref_out(128'h0123456789abcdef_fedcba9876543210, 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, 1'b0);
      send(0, 128'h0123456789abcdef_fedcba9876543210, 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, 1'b0, 1'b0);
      n = 0;
      while (!ov[0] && n < 20) begin @(negedge clk); n++; end
      a0 = acc_cnt[0];
      h0 = hs_cnt[0];
      for (int j = 0; j < 10; j++) begin
         @(posedge clk); #1;
         iv[0] = j[0];
         ist[0] = {4{$urandom}};
         sk[0] = j[1];
         @(negedge clk);
         chk("bp_hold", {ov[0], ir[0], os[0]}, {1'b1, 1'b0, exp_a});
      end
      chk("bp_no_accept", 128'(acc_cnt[0] - a0), 128'(0));
      @(posedge clk); #1;
      iv[0] = 1'b0;
      orr[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_one_handshake", 128'(hs_cnt[0] - h0), 128'(1));
      chk("bp_after", {ov[0], ir[0], os[0]}, {1'b0, 1'b1, exp_a});

      s_b = {4{$urandom}};
      k_b = {4{$urandom}};
      send(0, s_b, k_b, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_state", {ov[0], ir[0], bsy[0], os[0]}, {1'b0, 1'b1, 1'b0, 128'h0});
      sbq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      h0 = hs_cnt[0];
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_output", 128'(hs_cnt[0] - h0), 128'(0));
      send(0, MIX_IN, 128'h0, 1'b0, 1'b0);
      wait_out(0, 1'b1);
      chk("postrst_out", os[0], MIX_OUT);

      orr = '1;
      fork
         stream(0);
         stream(1);
         stream(2);
      join
      chk("sb_empty", 128'(sbq.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inv_addkey_mixcol_seq.md
Name: inv_addkey_mixcol_seq

Overview:
Decryption-path stage directly downstream of InvSubBytes. It consumes the 128-bit substituted state, applies AddRoundKey with the current round key, then applies InvMixColumns column-serially over several cycles. Handshakes are valid/ready on both sides. skip_mix bypasses InvMixColumns for the final inverse round.

Parameters:
COLS_PER_CYCLE, 1, number of columns transformed per clock; legal values 1, 2, 4. N = 4/COLS_PER_CYCLE processing cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instate/roundkey/skip_mix are valid
in_ready  output  1  block can accept; equals (state==IDLE)
instate  input  128  state from InvSubBytes
roundkey  input  128  round key for this round
skip_mix  input  1  1 = AddRoundKey only (final inverse round)
out_valid  output  1  outstate is valid
out_ready  input  1  downstream accepts outstate
outstate  output  128  result state
busy  output  1  state != IDLE

Behaviour:
- Byte map: byte k = instate[127-8k -: 8]. Column c = bytes 4c..4c+3, with row 0 in the MSB byte.
- InvMixColumns per column (s0..s3):
  - s0' = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - rows rotate the coefficients: s1' = 09,0e,0b,0d; s2' = 0d,09,0e,0b; s3' = 0b,0d,09,0e
  - GF(2^8) multiply, reduction polynomial 0x11B, built from xtime chains; no multipliers or lookup tables.
- Reset (async assert, sync deassert handled externally):
  - state=IDLE, out_valid=0, outstate=0, column counter=0, internal buffer=0, latched skip flag=0
  - in_ready=1 and busy=0 while in IDLE.
- FSM IDLE / PROC / DONE:
  - IDLE: on in_valid&&in_ready at edge E0, buf <= instate ^ roundkey and skip flag latched. Next state is PROC if skip_mix=0 and DONE if skip_mix=1. col_cnt <= 0.
  - PROC: each edge transforms columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of buf in place, and col_cnt += COLS_PER_CYCLE. After the edge that processes column 3, go to DONE and copy buf to outstate.
  - DONE: out_valid=1 and outstate held stable. On out_valid&&out_ready, go to IDLE; out_valid drops on that edge.
- Latency: out_valid is high in the cycle after edge E0+N (skip_mix=0) or after E0 (skip_mix=1).
- Throughput with constant in_valid and out_ready: one block per N+2 cycles. in_ready is 0 in PROC and DONE, with no overlap.
- AddRoundKey is applied before InvMixColumns (equivalent-inverse ordering is not used).
- Inputs are sampled only on the accept edge. Changes to instate, roundkey or skip_mix afterwards have no effect.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; upstream must hold it.
- outstate holds its last value after leaving DONE; it is not cleared.
- Reset mid-PROC or mid-DONE aborts immediately. A partial result is never presented, and out_valid=0 in the same cycle reset asserts.
- Column counter wraps only via the state transition; no out-of-range column index is ever used.

Test Plan:
- COLS_PER_CYCLE=1, roundkey=0, skip_mix=0, instate=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> outstate=db135345_f20a225c_01010101_c6c6c6c6. out_valid high after edge E0+4; in_ready=0 during E1..E5.
- skip_mix=1, instate=00112233445566778899aabbccddeeff, roundkey=000102030405060708090a0b0c0d0e0f -> outstate=00102030405060708090a0b0c0d0e0f0, out_valid high in the cycle after E0.
- instate=0, roundkey=8e4da1bc_9fdc589d_01010101_c6c6c6c6, skip_mix=0 -> outstate=db135345_f20a225c_01010101_c6c6c6c6 (confirms XOR precedes mix).
- Back-pressure: out_ready=0 for 10 cycles in DONE, new in_valid pulses with different data -> outstate and out_valid stable, in_ready=0, no second accept. Raising out_ready gives exactly one output handshake.
- Reset pulse (rst_n=0 for 1 cycle) during PROC column 2 -> out_valid=0, outstate=0, in_ready=1. The next block after reset yields a correct result with no residue.
- Streaming: in_valid=1 and out_ready=1 continuously, 4 distinct blocks, run for COLS_PER_CYCLE=1, 2, 4 -> all 4 outputs correct and in order, spaced 6, 4 and 3 cycles respectively.
